// File: rtl/spi_rx_fifo.sv
// Receive FIFO behind an SPI slave: first-word fall-through storage, fill level,
// hysteresis busy line toward the SPI master and a sticky overflow flag.
module spi_rx_fifo #(
    parameter int unsigned WORD_W    = 64,
    parameter int unsigned DEPTH     = 16,
    parameter int unsigned AFULL_LVL = 12,
    parameter int unsigned ALOW_LVL  = 4
) (
    input  logic                     CLK100MHZ,
    input  logic                     ck_rst,
    input  logic                     in_dv,
    input  logic [WORD_W-1:0]        in_word,
    output logic                     out_valid,
    output logic [WORD_W-1:0]        out_word,
    input  logic                     out_ready,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     busy,
    output logic                     overflow,
    input  logic                     clr_ovf
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned LVL_W = PTR_W + 1;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } state_t;

    logic [WORD_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [LVL_W-1:0]  level_nxt;
    logic              full;
    logic              push;
    logic              pop;
    logic              drop;
    state_t            state_q;
    state_t            state_d;

    assign full = (level == LVL_W'(DEPTH));
    assign pop  = out_valid & out_ready;
    // A full FIFO still accepts a word when the head leaves in the same cycle.
    assign push = in_dv & (~full | pop);
    assign drop = in_dv & full & ~pop;

    always_comb begin
        level_nxt = level;
        case ({push, pop})
            2'b10:   level_nxt = level + LVL_W'(1);
            2'b01:   level_nxt = level - LVL_W'(1);
            default: level_nxt = level;
        endcase
    end

    // Storage is data only; it carries no reset.
    always_ff @(posedge CLK100MHZ) begin
        if (push) begin
            mem[wr_ptr] <= in_word;
        end
    end

    assign out_word = mem[rd_ptr];

    always_ff @(posedge CLK100MHZ) begin
        if (ck_rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            level     <= '0;
            out_valid <= 1'b0;
            overflow  <= 1'b0;
            state_q   <= S_IDLE;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            level     <= level_nxt;
            out_valid <= (level_nxt != '0);
            // A drop wins over a simultaneous clear so no loss goes unreported.
            if (drop) begin
                overflow <= 1'b1;
            end else if (clr_ovf) begin
                overflow <= 1'b0;
            end
            state_q <= state_d;
        end
    end

    // Busy hysteresis is evaluated on the next level so it moves with level.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (level_nxt >= LVL_W'(AFULL_LVL)) state_d = S_BUSY;
            S_BUSY: if (level_nxt <= LVL_W'(ALOW_LVL))  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    assign busy = (state_q == S_BUSY);

endmodule

// File: tb/tb_spi_rx_fifo.sv
// Directed bench for spi_rx_fifo with DEPTH=4, AFULL_LVL=3, ALOW_LVL=1.
module tb_spi_rx_fifo;

    localparam logic [63:0] W1 = 64'h1111_1111_1111_1111;
    localparam logic [63:0] W2 = 64'h2222_2222_2222_2222;
    localparam logic [63:0] W3 = 64'h3333_3333_3333_3333;
    localparam logic [63:0] W4 = 64'h4444_4444_4444_4444;
    localparam logic [63:0] WD = 64'hDEAD_DEAD_DEAD_DEAD;
    localparam logic [63:0] W5 = 64'h5555_5555_5555_5555;

    logic        clk = 1'b0;
    logic        ck_rst = 1'b1;
    logic        in_dv = 1'b0;
    logic [63:0] in_word = '0;
    logic        out_valid;
    logic [63:0] out_word;
    logic        out_ready = 1'b0;
    logic [2:0]  level;
    logic        busy;
    logic        overflow;
    logic        clr_ovf = 1'b0;

    int errors = 0;
    int checks = 0;

    spi_rx_fifo #(.WORD_W(64), .DEPTH(4), .AFULL_LVL(3), .ALOW_LVL(1)) dut (
        .CLK100MHZ(clk), .ck_rst(ck_rst), .in_dv(in_dv), .in_word(in_word),
        .out_valid(out_valid), .out_word(out_word), .out_ready(out_ready),
        .level(level), .busy(busy), .overflow(overflow), .clr_ovf(clr_ovf)
    );

    always #5 clk = ~clk;

    // One clock: apply inputs, take the edge, then return inputs to idle.
    task automatic step(input logic dv, input logic [63:0] w, input logic rdy,
                        input logic clr, input logic rst);
        in_dv = dv; in_word = w; out_ready = rdy; clr_ovf = clr; ck_rst = rst;
        @(posedge clk); #1;
        in_dv = 1'b0; in_word = '0; out_ready = 1'b0; clr_ovf = 1'b0; ck_rst = 1'b0;
    endtask

    task automatic test_reset();
        step(1'b1, W5, 1'b1, 1'b0, 1'b1);
        step(1'b1, W5, 1'b1, 1'b0, 1'b1);
        checks++; if (level !== 3'd0) begin errors++; $display("FAIL reset_level got=%0d exp=0", level); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", out_valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_ovf got=%b exp=0", overflow); end
    endtask

    task automatic test_fill();
        logic [63:0] w [3];
        logic [2:0]  el [3];
        logic        eb [3];
        w[0] = W1; w[1] = W2; w[2] = W3;
        el[0] = 3'd1; el[1] = 3'd2; el[2] = 3'd3;
        eb[0] = 1'b0; eb[1] = 1'b0; eb[2] = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step(1'b1, w[i], 1'b0, 1'b0, 1'b0);
            checks++; if (level !== el[i]) begin errors++; $display("FAIL fill_level[%0d] got=%0d exp=%0d", i, level, el[i]); end
            checks++; if (busy !== eb[i]) begin errors++; $display("FAIL fill_busy[%0d] got=%b exp=%b", i, busy, eb[i]); end
            checks++; if (out_valid !== 1'b1 || out_word !== W1) begin
                errors++; $display("FAIL fill_head[%0d] got=%b/%h exp=1/%h", i, out_valid, out_word, W1); end
        end
    endtask

    task automatic test_overflow();
        logic [63:0] ew [4];
        logic [2:0]  el [4];
        logic        eb [4];
        ew[0] = W1; ew[1] = W2; ew[2] = W3; ew[3] = W4;
        el[0] = 3'd3; el[1] = 3'd2; el[2] = 3'd1; el[3] = 3'd0;
        eb[0] = 1'b1; eb[1] = 1'b1; eb[2] = 1'b0; eb[3] = 1'b0;
        step(1'b1, W4, 1'b0, 1'b0, 1'b0);
        checks++; if (level !== 3'd4) begin errors++; $display("FAIL ovf_fill_level got=%0d exp=4", level); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_pre got=%b exp=0", overflow); end
        step(1'b1, WD, 1'b0, 1'b0, 1'b0);
        checks++; if (level !== 3'd4) begin errors++; $display("FAIL ovf_drop_level got=%0d exp=4", level); end
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_set got=%b exp=1", overflow); end
        for (int i = 0; i < 4; i++) begin
            checks++; if (out_valid !== 1'b1 || out_word !== ew[i]) begin
                errors++; $display("FAIL ovf_pop_word[%0d] got=%b/%h exp=1/%h", i, out_valid, out_word, ew[i]); end
            step(1'b0, '0, 1'b1, 1'b0, 1'b0);
            checks++; if (level !== el[i] || busy !== eb[i]) begin
                errors++; $display("FAIL ovf_pop_lvl[%0d] got=%0d/%b exp=%0d/%b", i, level, busy, el[i], eb[i]); end
        end
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky got=%b exp=1", overflow); end
        step(1'b0, '0, 1'b1, 1'b1, 1'b0);
        checks++; if (overflow !== 1'b0 || level !== 3'd0) begin
            errors++; $display("FAIL ovf_clear got=%b/%0d exp=0/0", overflow, level); end
    endtask

    task automatic test_full_pushpop();
        logic [63:0] ew [4];
        ew[0] = W2; ew[1] = W3; ew[2] = W4; ew[3] = W5;
        step(1'b1, W1, 1'b0, 1'b0, 1'b0);
        step(1'b1, W2, 1'b0, 1'b0, 1'b0);
        step(1'b1, W3, 1'b0, 1'b0, 1'b0);
        step(1'b1, W4, 1'b0, 1'b0, 1'b0);
        checks++; if (level !== 3'd4 || busy !== 1'b1) begin
            errors++; $display("FAIL fpp_full got=%0d/%b exp=4/1", level, busy); end
        step(1'b1, W5, 1'b1, 1'b0, 1'b0);
        checks++; if (level !== 3'd4) begin errors++; $display("FAIL fpp_level got=%0d exp=4", level); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL fpp_ovf got=%b exp=0", overflow); end
        for (int i = 0; i < 4; i++) begin
            checks++; if (out_word !== ew[i]) begin
                errors++; $display("FAIL fpp_order[%0d] got=%h exp=%h", i, out_word, ew[i]); end
            step(1'b0, '0, 1'b1, 1'b0, 1'b0);
        end
        checks++; if (level !== 3'd0 || out_valid !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL fpp_empty got=%0d/%b/%b exp=0/0/0", level, out_valid, busy); end
    endtask

    task automatic test_hysteresis();
        step(1'b1, W1, 1'b0, 1'b0, 1'b0);
        step(1'b1, W2, 1'b0, 1'b0, 1'b0);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL hys_below got=%b exp=0", busy); end
        step(1'b1, W3, 1'b0, 1'b0, 1'b0);
        checks++; if (level !== 3'd3 || busy !== 1'b1) begin
            errors++; $display("FAIL hys_rise got=%0d/%b exp=3/1", level, busy); end
        step(1'b0, '0, 1'b1, 1'b0, 1'b0);
        checks++; if (level !== 3'd2 || busy !== 1'b1) begin
            errors++; $display("FAIL hys_hold got=%0d/%b exp=2/1", level, busy); end
        step(1'b0, '0, 1'b1, 1'b0, 1'b0);
        checks++; if (level !== 3'd1 || busy !== 1'b0) begin
            errors++; $display("FAIL hys_fall got=%0d/%b exp=1/0", level, busy); end
        step(1'b1, W4, 1'b0, 1'b0, 1'b0);
        checks++; if (level !== 3'd2 || busy !== 1'b0) begin
            errors++; $display("FAIL hys_regrow got=%0d/%b exp=2/0", level, busy); end
        checks++; if (out_word !== W3) begin errors++; $display("FAIL hys_head got=%h exp=%h", out_word, W3); end
        step(1'b0, '0, 1'b1, 1'b0, 1'b0);
        step(1'b0, '0, 1'b1, 1'b0, 1'b0);
        checks++; if (level !== 3'd0) begin errors++; $display("FAIL hys_drain got=%0d exp=0", level); end
    endtask

    task automatic test_stream();
        logic [63:0] w;
        logic [63:0] prev;
        prev = '0;
        for (int i = 0; i < 10; i++) begin
            w = 64'hC0DE_0000_0000_0000 | 64'(i);
            if (i > 0) begin
                checks++; if (out_valid !== 1'b1 || out_word !== prev) begin
                    errors++; $display("FAIL stream_word[%0d] got=%b/%h exp=1/%h", i, out_valid, out_word, prev); end
            end
            step(1'b1, w, 1'b1, 1'b0, 1'b0);
            checks++; if (level !== 3'd1 || busy !== 1'b0) begin
                errors++; $display("FAIL stream_level[%0d] got=%0d/%b exp=1/0", i, level, busy); end
            prev = w;
        end
        checks++; if (out_word !== prev) begin errors++; $display("FAIL stream_last got=%h exp=%h", out_word, prev); end
        step(1'b0, '0, 1'b1, 1'b0, 1'b0);
        checks++; if (level !== 3'd0 || out_valid !== 1'b0) begin
            errors++; $display("FAIL stream_end got=%0d/%b exp=0/0", level, out_valid); end
    endtask

    task automatic test_reset_mid();
        step(1'b1, W1, 1'b0, 1'b0, 1'b0);
        step(1'b1, W2, 1'b0, 1'b0, 1'b0);
        step(1'b1, W3, 1'b0, 1'b0, 1'b0);
        step(1'b1, W4, 1'b0, 1'b0, 1'b0);
        step(1'b1, WD, 1'b0, 1'b0, 1'b0);
        step(1'b0, '0, 1'b1, 1'b0, 1'b0);
        step(1'b0, '0, 1'b1, 1'b0, 1'b0);
        checks++; if (level !== 3'd2 || busy !== 1'b1 || overflow !== 1'b1) begin
            errors++; $display("FAIL rmid_pre got=%0d/%b/%b exp=2/1/1", level, busy, overflow); end
        step(1'b1, W5, 1'b1, 1'b0, 1'b1);
        checks++; if (level !== 3'd0 || out_valid !== 1'b0 || busy !== 1'b0 || overflow !== 1'b0) begin
            errors++; $display("FAIL rmid_state got=%0d/%b/%b/%b exp=0/0/0/0", level, out_valid, busy, overflow); end
        step(1'b1, W5, 1'b0, 1'b0, 1'b0);
        checks++; if (level !== 3'd1 || out_word !== W5) begin
            errors++; $display("FAIL rmid_first got=%0d/%h exp=1/%h", level, out_word, W5); end
        step(1'b1, W2, 1'b0, 1'b0, 1'b0);
        step(1'b1, W3, 1'b0, 1'b0, 1'b0);
        step(1'b1, W4, 1'b0, 1'b0, 1'b0);
        step(1'b1, WD, 1'b0, 1'b1, 1'b0);
        checks++; if (overflow !== 1'b1 || level !== 3'd4) begin
            errors++; $display("FAIL drop_clr got=%b/%0d exp=1/4", overflow, level); end
        step(1'b0, '0, 1'b0, 1'b1, 1'b0);
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL clr_only got=%b exp=0", overflow); end
        checks++; if (out_word !== W5) begin errors++; $display("FAIL drop_head got=%h exp=%h", out_word, W5); end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_overflow();
        test_full_pushpop();
        test_hysteresis();
        test_stream();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
